// File: rtl/cla_seq_adder_if.sv
// Request/result bundle for cla_seq_adder: valid/ready request carrying the
// operands, valid/ready result carrying sum and carry-out, plus a busy flag.
interface cla_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry look-ahead adder is
// applied to one nibble per cycle, LSB first, with the carry registered between passes.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] c;

   assign p = a ^ b;
   assign g = a & b;

   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c0);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c0);
   assign s = p ^ c;
endmodule

module cla_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_seq_adder_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB);
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
      end
      if ($bits(bus.sum) != WIDTH) begin : g_bad_if_width
         $error("cla_seq_adder: interface WIDTH does not match module WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic [CW-1:0]    cnt_reg;

   logic [CW+1:0]    nib_sel;
   logic [3:0]       cla_s;
   logic             cla_cout;
   logic             last_nib;

   // Bit offset of the current nibble is simply the counter times four.
   assign nib_sel  = {cnt_reg, 2'b00};
   assign last_nib = (cnt_reg == LAST);

   cla4 u_cla (
      .a    (a_reg[nib_sel +: 4]),
      .b    (b_reg[nib_sel +: 4]),
      .c0   (carry_reg),
      .s    (cla_s),
      .cout (cla_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a;
                  b_reg     <= bus.b;
                  carry_reg <= bus.cin;
                  cnt_reg   <= '0;
               end
            end
            RUN: begin
               sum_reg[nib_sel +: 4] <= cla_s;
               carry_reg             <= cla_cout;
               // Counter parks on the last nibble; it is reloaded on the next accept.
               if (last_nib) begin
                  cout_reg <= cla_cout;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sum  = sum_reg;
   assign bus.cout = cout_reg;
endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle wide adder sequencer for the MAC accumulate path.
- Time-shares one instance of the existing 4-bit carry look-ahead adder (ports a, b, c0, s, cout) to add two WIDTH-bit operands, one nibble per cycle, LSB nibble first.
- The carry is registered between nibbles.
- Uses valid/ready handshakes on both sides so the MAC scheduler can issue accumulate requests and stall on results.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. Non-multiples are a compile-time error via a generate check.
- NIB, WIDTH/4, derived localparam: number of nibble passes.
- CW, $clog2(NIB), derived localparam: nibble counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to the LSB nibble.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release of state):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Operand registers, carry register and nibble counter are all cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1: capture a, b into operand registers and cin into the carry register, set the counter to 0, go to RUN.
  - sum and cout keep their last values (0 after reset).
- RUN (NIB cycles):
  - in_ready=0.
  - Each cycle, the CLA inputs are a_reg[4k+3:4k], b_reg[4k+3:4k] and c0=carry_reg, where k is the counter value.
  - At the clock edge: sum[4k+3:4k] <= s, carry_reg <= CLA cout, k <= k+1.
  - When k = NIB-1: cout <= CLA cout, go to DONE.
  - Other sum nibbles are not cleared at accept. They are overwritten in order, so intermediate sum is undefined to the consumer while out_valid=0.
- DONE:
  - out_valid=1. sum and cout are stable and held.
  - When out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle accept; the next request is taken in IDLE.
- Latency:
  - Request accepted at edge T; out_valid rises after edge T+NIB.
  - Throughput is at most one result per NIB+2 cycles when out_ready is held high.
- Operands are sampled only at acceptance. Later changes on a, b or cin have no effect.
- in_valid while busy is ignored; the requester must hold it until in_ready=1.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is reported only via cout. Unsigned.
- Backpressure: out_ready=0 holds DONE indefinitely with no change to sum or cout.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. No partial result is ever flagged valid.
- Only a single CLA instance is permitted. No additional adders on the data path.
- Counter wrap: the counter never exceeds NIB-1. It is reloaded to 0 on accept.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, in_valid one cycle in IDLE -> in_ready drops next cycle; out_valid rises 4 cycles after the accept edge with sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 passes). a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x8000, b=0x8000, cin=1 with out_ready=0 for 6 cycles after out_valid -> sum=0x0001, cout=1 held stable; in_ready=0, busy=1 throughout. Then out_ready=1 -> out_valid=0 and in_ready=1 on the following cycle.
- Accept a=0x00FF, b=0x0001, then change a and b to 0xAAAA every cycle during RUN and pulse in_valid -> result still sum=0x0100, cout=0; no second request accepted until IDLE.
- Assert rst_n=0 for one cycle during the 2nd RUN cycle -> out_valid, sum, cout, busy go to 0 asynchronously, in_ready=1. A new request 0x0F0F+0xF0F0 then yields sum=0xFFFF, cout=0.
- Back-to-back: 3 requests with out_ready tied high -> results spaced exactly NIB+2=6 cycles apart, each matching the reference model a+b+cin.
